// File: rtl/systolic_array_stream.sv
`default_nettype none
// ============================================================================
// systolic_array_stream: output-stationary ROWSxCOLS systolic matrix multiply,
// one k-slice per handshake, optional accumulate, MAC/cycle perf counters.
// Revision: 1.0
// ============================================================================
module systolic_array_stream #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int RESULT_WIDTH = 32,
  parameter int K_MAX        = 255
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         acc_mode,
  input  logic [$clog2(K_MAX+1)-1:0]                   k_len,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [0:ROWS-1][DATA_WIDTH-1:0]              a_vec,
  input  logic [0:COLS-1][DATA_WIDTH-1:0]              b_vec,
  output logic [0:ROWS-1][0:COLS-1][RESULT_WIDTH-1:0]  output_data,
  output logic                                         busy,
  output logic                                         done,
  output logic [RESULT_WIDTH-1:0]                      total_mac_operations,
  output logic [RESULT_WIDTH-1:0]                      total_cycles
);

  localparam int KW        = $clog2(K_MAX+1);
  localparam int DRAIN_LEN = ROWS + COLS - 1;
  localparam int DCW       = $clog2(DRAIN_LEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [KW-1:0]           r_k_len;
  logic [KW-1:0]           r_k_cnt;
  logic [DCW-1:0]          r_drain;

  logic                    w_start_ok;
  logic                    w_xfer;
  logic                    w_last_xfer;
  logic                    w_clear;

  // Operands presented to each PE this cycle, with their valid bits
  logic [DATA_WIDTH-1:0]   w_a_in     [ROWS][COLS];
  logic [DATA_WIDTH-1:0]   w_b_in     [ROWS][COLS];
  logic                    w_av_in    [ROWS][COLS];
  logic                    w_bv_in    [ROWS][COLS];
  logic                    w_mac      [ROWS][COLS];
  logic [RESULT_WIDTH-1:0] w_prod_ext [ROWS][COLS];
  logic [RESULT_WIDTH-1:0] w_mac_sum;

  // Operands leaving each PE, consumed by the right / lower neighbour
  logic [DATA_WIDTH-1:0]   r_a_pass   [ROWS][COLS];
  logic [DATA_WIDTH-1:0]   r_b_pass   [ROWS][COLS];
  logic                    r_av_pass  [ROWS][COLS];
  logic                    r_bv_pass  [ROWS][COLS];
  logic [RESULT_WIDTH-1:0] r_acc      [ROWS][COLS];

  assign in_ready    = (r_state == S_LOAD);
  assign busy        = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xfer      = in_valid && in_ready;
  assign w_last_xfer = ((r_k_cnt + KW'(1)) == r_k_len);
  assign w_clear     = w_start_ok && !acc_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = (k_len != '0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (w_xfer && w_last_xfer) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == DCW'(DRAIN_LEN - 1)) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k_len <= '0;
      r_k_cnt <= '0;
      r_drain <= '0;
    end else begin
      if (w_start_ok) begin
        r_k_len <= k_len;
        r_k_cnt <= '0;
      end else if (w_xfer) begin
        r_k_cnt <= r_k_cnt + KW'(1);
      end
      if (r_state == S_DRAIN) begin
        r_drain <= r_drain + DCW'(1);
      end else begin
        r_drain <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_mac_operations <= '0;
      total_cycles         <= '0;
    end else if (w_start_ok) begin
      total_mac_operations <= '0;
      total_cycles         <= '0;
    end else begin
      total_mac_operations <= total_mac_operations + w_mac_sum;
      if (busy) begin
        total_cycles <= total_cycles + RESULT_WIDTH'(1);
      end
    end
  end

  // Row i of A enters column 0 after i register stages
  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_askew
      if (gi == 0) begin : g_direct
        assign w_a_in[0][0]  = a_vec[0];
        assign w_av_in[0][0] = w_xfer;
      end else begin : g_delay
        logic [DATA_WIDTH-1:0] r_sd [gi];
        logic                  r_sv [gi];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int d = 0; d < gi; d++) begin
              r_sd[d] <= '0;
              r_sv[d] <= 1'b0;
            end
          end else begin
            r_sd[0] <= a_vec[gi];
            r_sv[0] <= w_xfer;
            for (int d = 1; d < gi; d++) begin
              r_sd[d] <= r_sd[d-1];
              r_sv[d] <= r_sv[d-1];
            end
          end
        end
        assign w_a_in[gi][0]  = r_sd[gi-1];
        assign w_av_in[gi][0] = r_sv[gi-1];
      end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_bskew
      if (gj == 0) begin : g_direct
        assign w_b_in[0][0]  = b_vec[0];
        assign w_bv_in[0][0] = w_xfer;
      end else begin : g_delay
        logic [DATA_WIDTH-1:0] r_sd [gj];
        logic                  r_sv [gj];
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            for (int d = 0; d < gj; d++) begin
              r_sd[d] <= '0;
              r_sv[d] <= 1'b0;
            end
          end else begin
            r_sd[0] <= b_vec[gj];
            r_sv[0] <= w_xfer;
            for (int d = 1; d < gj; d++) begin
              r_sd[d] <= r_sd[d-1];
              r_sv[d] <= r_sv[d-1];
            end
          end
        end
        assign w_b_in[0][gj]  = r_sd[gj-1];
        assign w_bv_in[0][gj] = r_sv[gj-1];
      end
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_row
      for (gj = 0; gj < COLS; gj++) begin : g_col
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        if (gj > 0) begin : g_a_link
          assign w_a_in[gi][gj]  = r_a_pass[gi][gj-1];
          assign w_av_in[gi][gj] = r_av_pass[gi][gj-1];
        end
        if (gi > 0) begin : g_b_link
          assign w_b_in[gi][gj]  = r_b_pass[gi-1][gj];
          assign w_bv_in[gi][gj] = r_bv_pass[gi-1][gj];
        end
        // Full-width signed product, then sign-extended into the accumulator
        assign w_prod             = $signed(w_a_in[gi][gj]) * $signed(w_b_in[gi][gj]);
        assign w_prod_ext[gi][gj] = RESULT_WIDTH'(w_prod);
        assign w_mac[gi][gj]      = w_av_in[gi][gj] && w_bv_in[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          r_a_pass[i][j]  <= '0;
          r_b_pass[i][j]  <= '0;
          r_av_pass[i][j] <= 1'b0;
          r_bv_pass[i][j] <= 1'b0;
          r_acc[i][j]     <= '0;
        end
      end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        for (int j = 0; j < COLS; j++) begin
          r_a_pass[i][j]  <= w_a_in[i][j];
          r_b_pass[i][j]  <= w_b_in[i][j];
          r_av_pass[i][j] <= w_av_in[i][j];
          r_bv_pass[i][j] <= w_bv_in[i][j];
          if (w_clear) begin
            r_acc[i][j] <= '0;
          end else if (w_mac[i][j]) begin
            r_acc[i][j] <= r_acc[i][j] + w_prod_ext[i][j];
          end
        end
      end
    end
  end

  always_comb begin
    w_mac_sum = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        w_mac_sum = w_mac_sum + RESULT_WIDTH'(w_mac[i][j]);
        output_data[i][j] = r_acc[i][j];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_stream.sv
`default_nettype none
// tb_systolic_array_stream: directed, hand-computed checks of the 4x4 streaming
// systolic engine (results, latency, counters, bubbles, accumulate, reset).
module tb_systolic_array_stream;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int KW = 8;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          start;
  logic                          acc_mode;
  logic [KW-1:0]                 k_len;
  logic                          in_valid;
  logic                          in_ready;
  logic [0:R-1][DW-1:0]          a_vec;
  logic [0:C-1][DW-1:0]          b_vec;
  logic [0:R-1][0:C-1][RW-1:0]   output_data;
  logic                          busy;
  logic                          done;
  logic [RW-1:0]                 total_mac_operations;
  logic [RW-1:0]                 total_cycles;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] ma    [R][R];
  logic [DW-1:0] mb    [R][C];
  logic [RW-1:0] exp_m [R][C];

  int ec;
  int rdy_cnt;
  bit busy_seen;
  bit timed_out;

  always #5 clk = ~clk;

  systolic_array_stream #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .RESULT_WIDTH(RW), .K_MAX(255)
  ) u_dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .acc_mode             (acc_mode),
    .k_len                (k_len),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .a_vec                (a_vec),
    .b_vec                (b_vec),
    .output_data          (output_data),
    .busy                 (busy),
    .done                 (done),
    .total_mac_operations (total_mac_operations),
    .total_cycles         (total_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic set_ident_b();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < R; k++)
        ma[i][k] = (i == k) ? DW'(1) : DW'(0);
    for (int k = 0; k < R; k++)
      for (int j = 0; j < C; j++)
        mb[k][j] = DW'(4 * k + j + 1);
  endtask

  task automatic set_exp_b(input int scale);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        exp_m[i][j] = RW'(scale * (4 * i + j + 1));
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        chk($sformatf("%s[%0d][%0d]", tag, i, j), 64'(output_data[i][j]), 64'(exp_m[i][j]));
  endtask

  // Starts an operation and streams k slices; poke pulses start mid-LOAD,
  // abort>0 returns right after that many transfers.
  task automatic run_op(input int k, input bit acc, input bit bubble, input bit poke, input int abort);
    int  idx;
    bit  rdy;
    @(negedge clk);
    start = 1'b1; acc_mode = acc; k_len = KW'(k); in_valid = 1'b0;
    @(posedge clk);
    ec = 0; rdy_cnt = 0; busy_seen = 1'b0; timed_out = 1'b1; idx = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      if (abort > 0 && idx == abort) begin
        timed_out = 1'b0;
        break;
      end
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (in_ready) rdy_cnt++;
      if (busy) busy_seen = 1'b1;
      if (poke && c == 2) begin
        start = 1'b1; k_len = '0; acc_mode = 1'b0;
      end
      if (idx < k) begin
        in_valid = bubble ? (c % 2 == 0) : 1'b1;
        for (int r = 0; r < R; r++) a_vec[r] = ma[r][idx];
        for (int q = 0; q < C; q++) b_vec[q] = mb[idx][q];
      end
      rdy = in_ready;
      @(posedge clk);
      ec++;
      if (in_valid && rdy) idx++;
    end
    if (timed_out) chk("op_timeout_done", 64'(done), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; acc_mode = 1'b0; k_len = '0;
    in_valid = 1'b0; a_vec = '0; b_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_any", 64'(|output_data), 64'd0);
    chk("rst_macs", 64'(total_mac_operations), 64'd0);
    chk("rst_cycles", 64'(total_cycles), 64'd0);
    reset = 1'b0;

    // Identity times B, no bubbles
    set_ident_b();
    set_exp_b(1);
    run_op(4, 1'b0, 1'b0, 1'b0, 0);
    check_out("t1_out");
    chk("t1_done_cycle", 64'(ec + 1), 64'd12);
    chk("t1_cycles", 64'(total_cycles), 64'd11);
    chk("t1_macs", 64'(total_mac_operations), 64'd64);
    chk("t1_ready_cnt", 64'(rdy_cnt), 64'd4);

    // Bubbles every other cycle, plus a start pulse inside LOAD
    run_op(4, 1'b0, 1'b1, 1'b1, 0);
    check_out("t2_out");
    chk("t2_cycles", 64'(total_cycles), 64'd14);
    chk("t2_macs", 64'(total_mac_operations), 64'd64);
    chk("t2_done_cycle", 64'(ec + 1), 64'd15);
    chk("t2_ready_cnt", 64'(rdy_cnt), 64'd7);
    chk("t2_ready_in_done", 64'(in_ready), 64'd0);

    // Accumulate onto previous result, then clear again
    set_exp_b(2);
    run_op(4, 1'b1, 1'b0, 1'b0, 0);
    check_out("t3_acc");
    chk("t3_cycles", 64'(total_cycles), 64'd11);
    chk("t3_macs", 64'(total_mac_operations), 64'd64);
    set_exp_b(1);
    run_op(4, 1'b0, 1'b0, 1'b0, 0);
    check_out("t3_clr");

    // k_len = 0: keep (acc) then clear
    run_op(0, 1'b1, 1'b0, 1'b0, 0);
    chk("t4_done_cycle", 64'(ec + 1), 64'd1);
    chk("t4_busy_seen", 64'(busy_seen), 64'd0);
    chk("t4_macs", 64'(total_mac_operations), 64'd0);
    chk("t4_cycles", 64'(total_cycles), 64'd0);
    chk("t4_keep00", 64'(output_data[0][0]), 64'd1);
    chk("t4_keep33", 64'(output_data[3][3]), 64'd16);
    run_op(0, 1'b0, 1'b0, 1'b0, 0);
    chk("t4_clear_any", 64'(|output_data), 64'd0);
    chk("t4_done", 64'(done), 64'd1);

    // Signed: -1 * 2 summed over k=4
    for (int i = 0; i < R; i++)
      for (int k = 0; k < R; k++) begin
        ma[i][k] = 16'hFFFF;
        mb[k][i] = 16'd2;
      end
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        exp_m[i][j] = 32'hFFFF_FFF8;
    run_op(4, 1'b0, 1'b0, 1'b0, 0);
    check_out("t5_sgn");

    // Reset mid-LOAD after two transfers
    set_ident_b();
    run_op(4, 1'b1, 1'b0, 1'b0, 2);
    chk("t6_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_out_any", 64'(|output_data), 64'd0);
    chk("t6_macs", 64'(total_mac_operations), 64'd0);
    chk("t6_cycles", 64'(total_cycles), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    set_exp_b(1);
    run_op(4, 1'b0, 1'b0, 1'b0, 0);
    check_out("t6_rerun");
    chk("t6_rerun_cycles", 64'(total_cycles), 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
